// File: rtl/key_digit_display.sv
// Keypad entry into an 8-digit hex buffer, multiplexed onto a 7-segment display.
// Build macro LEADING_ZERO_BLANK_EN blanks positions at or above the entered digit count.
module key_digit_display #(
  parameter int SCAN_DIV = 10000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [19:0] key_data,
  output logic [7:0]  fnd_scan,
  output logic [7:0]  fnd_data,
  output logic        key_strobe,
  output logic [4:0]  key_code,
  output logic [3:0]  digit_count
);
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0]       RESET_SEG = 8'h00;
`else
  localparam logic [7:0]       RESET_SEG = 8'h3F;
`endif

  function automatic logic is_one_hot(input logic [19:0] v);
    return (v != 20'd0) && ((v & (v - 20'd1)) == 20'd0);
  endfunction

  function automatic logic [4:0] encode_key(input logic [19:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 20; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'h0: return 8'h3F;
      4'h1: return 8'h06;
      4'h2: return 8'h5B;
      4'h3: return 8'h4F;
      4'h4: return 8'h66;
      4'h5: return 8'h6D;
      4'h6: return 8'h7D;
      4'h7: return 8'h07;
      4'h8: return 8'h7F;
      4'h9: return 8'h6F;
      4'hA: return 8'h77;
      4'hB: return 8'h7C;
      4'hC: return 8'h39;
      4'hD: return 8'h5E;
      4'hE: return 8'h79;
      4'hF: return 8'h71;
      default: return 8'h00;
    endcase
  endfunction

  logic [19:0]      key_q_r;
  logic [19:0]      prev_q_r;
  logic             armed_r;
  logic             event_s;
  logic [4:0]       code_s;
  logic [3:0]       digit_r [8];
  logic [3:0]       count_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       idx_r;
  logic [7:0]       seg_s;

  assign digit_count = count_r;

  // Input sampling; armed_r stays low until the scanner has been seen idle after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_q_r  <= 20'd0;
      prev_q_r <= 20'd0;
      armed_r  <= 1'b0;
    end else begin
      key_q_r  <= key_data;
      prev_q_r <= key_q_r;
      armed_r  <= armed_r | (key_data == 20'd0);
    end
  end

  // Press-edge detection and key decode
  always_comb begin
    code_s  = encode_key(key_q_r);
    event_s = 1'b0;
    if (armed_r && (prev_q_r == 20'd0) && is_one_hot(key_q_r)) begin
      event_s = 1'b1;
    end else begin
      event_s = 1'b0;
    end
  end

  // Strobe, key code and digit buffer edits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_strobe <= 1'b0;
      key_code   <= 5'd0;
      count_r    <= 4'd0;
      for (int k = 0; k < 8; k++) digit_r[k] <= 4'd0;
    end else begin
      key_strobe <= event_s;
      if (event_s) begin
        key_code <= code_s;
        if (code_s < 5'd16) begin
          for (int k = 7; k > 0; k--) digit_r[k] <= digit_r[k-1];
          digit_r[0] <= code_s[3:0];
          if (count_r != 4'd8) count_r <= count_r + 4'd1;
        end else begin
          case (code_s)
            5'd16: begin
              for (int k = 0; k < 8; k++) digit_r[k] <= 4'd0;
              count_r <= 4'd0;
            end
            5'd17: begin
              if (count_r != 4'd0) begin
                for (int k = 0; k < 7; k++) digit_r[k] <= digit_r[k+1];
                digit_r[7] <= 4'd0;
                count_r    <= count_r - 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Segment pattern of the currently selected digit
  always_comb begin
    seg_s = seg_pattern(digit_r[idx_r]);
`ifdef LEADING_ZERO_BLANK_EN
    if ({1'b0, idx_r} >= count_r) begin
      seg_s = 8'h00;
    end else begin
      seg_s = seg_pattern(digit_r[idx_r]);
    end
`endif
  end

  // Free-running scan divider and registered display outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r    <= '0;
      idx_r    <= 3'd0;
      fnd_scan <= 8'h01;
      fnd_data <= RESET_SEG;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
        idx_r <= idx_r + 3'd1;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
      fnd_scan <= 8'h01 << idx_r;
      fnd_data <= seg_s;
    end
  end
endmodule

// File: tb/tb_key_digit_display.sv
// Directed self-checking bench for key_digit_display with SCAN_DIV=4.
`timescale 1ns/1ps
module tb_key_digit_display;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [19:0] key_data;
  logic [7:0]  fnd_scan;
  logic [7:0]  fnd_data;
  logic        key_strobe;
  logic [4:0]  key_code;
  logic [3:0]  digit_count;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  key_digit_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rstn(rstn), .key_data(key_data), .fnd_scan(fnd_scan),
    .fnd_data(fnd_data), .key_strobe(key_strobe), .key_code(key_code),
    .digit_count(digit_count)
  );

  always @(negedge clk) if (rstn && key_strobe) strobe_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int k, input int hold);
    key_data = 20'd1 << k;
    cyc(hold);
    key_data = 20'd0;
    cyc(4);
  endtask

  // waits (bounded) until digit k is selected; seg is X on timeout
  task automatic get_digit(input int k, output logic [7:0] seg);
    seg = 8'hxx;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (fnd_scan === (8'h01 << k)) begin
        seg = fnd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_seg;
    int base;
    exp_seg = LZB ? 8'h00 : 8'h3F;
    rstn = 1'b0; key_data = 20'd0;
    #12;
    checks++; if (fnd_scan !== 8'h01) begin errors++; $display("FAIL rst_scan got %h exp 01", fnd_scan); end
    checks++; if (fnd_data !== exp_seg) begin errors++; $display("FAIL rst_data got %h exp %h", fnd_data, exp_seg); end
    checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", digit_count); end
    checks++; if (key_strobe !== 1'b0 || key_code !== 5'd0) begin errors++; $display("FAIL rst_key got %b/%0d exp 0/0", key_strobe, key_code); end
    cyc(1); rstn = 1'b1;
    cyc(10);
    key_data = 20'd1 << 7;
    cyc(2);
    checks++; if (key_strobe !== 1'b1) begin errors++; $display("FAIL pre_rst_strobe got %b exp 1", key_strobe); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (fnd_scan !== 8'h01) begin errors++; $display("FAIL mid_rst_scan got %h exp 01", fnd_scan); end
    checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", digit_count); end
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe got %b exp 0", key_strobe); end
    cyc(1); rstn = 1'b1;
    base = strobe_cnt;
    cyc(10);
    checks++; if (strobe_cnt !== base || digit_count !== 4'd0) begin errors++; $display("FAIL held_after_rst strobes %0d count %0d exp 0 0", strobe_cnt - base, digit_count); end
    key_data = 20'd0; cyc(4);
    press(7, 3);
    checks++; if (strobe_cnt !== base + 1 || digit_count !== 4'd1) begin errors++; $display("FAIL repress_after_rst strobes %0d count %0d exp 1 1", strobe_cnt - base, digit_count); end
  endtask

  task automatic test_entry();
    logic [7:0] seg;
    int base;
    press(16, 3);
    base = strobe_cnt;
    key_data = 20'd1 << 1;
    cyc(1);
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL lat_edge1 got %b exp 0", key_strobe); end
    cyc(1);
    checks++; if (key_strobe !== 1'b1 || key_code !== 5'd1 || digit_count !== 4'd1) begin errors++; $display("FAIL lat_edge2 got %b/%0d/%0d exp 1/1/1", key_strobe, key_code, digit_count); end
    cyc(1);
    checks++; if (key_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width got %b exp 0", key_strobe); end
    key_data = 20'd0; cyc(4);
    press(2, 3); press(3, 3);
    checks++; if (strobe_cnt - base !== 3 || digit_count !== 4'd3) begin errors++; $display("FAIL entry_count strobes %0d count %0d exp 3 3", strobe_cnt - base, digit_count); end
    get_digit(0, seg);
    checks++; if (seg !== 8'h4F) begin errors++; $display("FAIL entry_d0 got %h exp 4F", seg); end
    get_digit(1, seg);
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL entry_d1 got %h exp 5B", seg); end
    get_digit(2, seg);
    checks++; if (seg !== 8'h06) begin errors++; $display("FAIL entry_d2 got %h exp 06", seg); end
    get_digit(3, seg);
    checks++; if (seg !== (LZB ? 8'h00 : 8'h3F)) begin errors++; $display("FAIL entry_d3 got %h exp %h", seg, LZB ? 8'h00 : 8'h3F); end
  endtask

  task automatic test_saturation();
    logic [7:0] seg;
    press(16, 3);
    for (int v = 1; v <= 9; v++) press(v, 3);
    checks++; if (digit_count !== 4'd8 || key_code !== 5'd9) begin errors++; $display("FAIL sat_count got %0d/%0d exp 8/9", digit_count, key_code); end
    get_digit(7, seg);
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL sat_d7 got %h exp 5B", seg); end
    get_digit(0, seg);
    checks++; if (seg !== 8'h6F) begin errors++; $display("FAIL sat_d0 got %h exp 6F", seg); end
    press(17, 3);
    checks++; if (digit_count !== 4'd7) begin errors++; $display("FAIL bs_count got %0d exp 7", digit_count); end
    get_digit(0, seg);
    checks++; if (seg !== 8'h7F) begin errors++; $display("FAIL bs_d0 got %h exp 7F", seg); end
    get_digit(6, seg);
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL bs_d6 got %h exp 5B", seg); end
    get_digit(7, seg);
    checks++; if (seg !== (LZB ? 8'h00 : 8'h3F)) begin errors++; $display("FAIL bs_d7 got %h exp %h", seg, LZB ? 8'h00 : 8'h3F); end
  endtask

  task automatic test_filter();
    logic [7:0] seg;
    int base;
    press(16, 3);
    base = strobe_cnt;
    press(5, 100);
    checks++; if (strobe_cnt - base !== 1 || digit_count !== 4'd1) begin errors++; $display("FAIL hold strobes %0d count %0d exp 1 1", strobe_cnt - base, digit_count); end
    key_data = 20'h00003; cyc(10); key_data = 20'd0; cyc(4);
    checks++; if (strobe_cnt - base !== 1 || digit_count !== 4'd1) begin errors++; $display("FAIL multibit strobes %0d count %0d exp 1 1", strobe_cnt - base, digit_count); end
    key_data = 20'd1 << 5; cyc(5);
    key_data = 20'd1 << 6; cyc(10);
    key_data = 20'd0; cyc(4);
    checks++; if (strobe_cnt - base !== 2 || digit_count !== 4'd2 || key_code !== 5'd5) begin errors++; $display("FAIL change strobes %0d count %0d code %0d exp 2 2 5", strobe_cnt - base, digit_count, key_code); end
    get_digit(0, seg);
    checks++; if (seg !== 8'h6D) begin errors++; $display("FAIL change_d0 got %h exp 6D", seg); end
  endtask

  task automatic test_clear_scan();
    logic [7:0] prev;
    logic [7:0] exp_scan;
    bit found;
    int base;
    press(16, 3);
    checks++; if (digit_count !== 4'd0 || key_code !== 5'd16) begin errors++; $display("FAIL clear got %0d/%0d exp 0/16", digit_count, key_code); end
    base = strobe_cnt;
    press(17, 3);
    checks++; if (digit_count !== 4'd0 || key_code !== 5'd17 || strobe_cnt - base !== 1) begin errors++; $display("FAIL bs_empty got %0d/%0d/%0d exp 0/17/1", digit_count, key_code, strobe_cnt - base); end
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = fnd_scan;
      cyc(1);
      if (prev !== 8'h01 && fnd_scan === 8'h01) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_sync got timeout exp 01 edge"); end
    exp_scan = 8'h01;
    for (int j = 1; j <= 8; j++) begin
      cyc(3);
      checks++; if (fnd_scan !== exp_scan) begin errors++; $display("FAIL scan_hold%0d got %h exp %h", j, fnd_scan, exp_scan); end
      exp_scan = {exp_scan[6:0], exp_scan[7]};
      cyc(1);
      checks++; if (fnd_scan !== exp_scan) begin errors++; $display("FAIL scan_step%0d got %h exp %h", j, fnd_scan, exp_scan); end
    end
  endtask

  task automatic test_blank();
    logic [7:0] seg;
    press(16, 3);
    press(10, 3); press(11, 3);
    checks++; if (digit_count !== 4'd2) begin errors++; $display("FAIL blank_count got %0d exp 2", digit_count); end
    get_digit(5, seg);
    checks++; if (seg !== (LZB ? 8'h00 : 8'h3F)) begin errors++; $display("FAIL blank_d5 got %h exp %h", seg, LZB ? 8'h00 : 8'h3F); end
    get_digit(1, seg);
    checks++; if (seg !== 8'h77) begin errors++; $display("FAIL blank_d1 got %h exp 77", seg); end
    press(18, 3);
    checks++; if (digit_count !== 4'd2 || key_code !== 5'd18) begin errors++; $display("FAIL key18 got %0d/%0d exp 2/18", digit_count, key_code); end
    press(19, 3);
    get_digit(0, seg);
    checks++; if (seg !== 8'h7C || key_code !== 5'd19 || digit_count !== 4'd2) begin errors++; $display("FAIL key19 got %h/%0d/%0d exp 7C/19/2", seg, key_code, digit_count); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_saturation();
    test_filter();
    test_clear_scan();
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
